uart_rx: RTL
============

Name: uart_rx

Overview:
- UART receiver: the receive-side counterpart of the team's UART transmitter.
- Oversamples the serial line by a runtime prescale and recovers start/data/optional parity/stop frames, LSB first.
- Delivers each byte on a parallel bus with a one-cycle valid strobe, and flags parity and framing errors.
- Sits between the pad-side RX line and the system-side register file/FIFO. Its frame format matches the transmitter: parity_type 0 = even, 1 = odd; one stop bit; idle line high.

Parameters:
DATA_WIDTH, 8, number of data bits per frame
PRESCALE_W, 6, width of the prescale input

Ports:
CLK  input  1  oversampling clock (prescale x bit rate)
RST  input  1  asynchronous, active-high reset
RX_IN  input  1  serial line, asynchronous to CLK, idle high
prescale  input  PRESCALE_W  oversampling ratio; legal values 8, 16, 32
parity_enable  input  1  1 = parity bit present after data bits
parity_type  input  1  0 = even, 1 = odd
P_DATA  output  DATA_WIDTH  last good received byte
data_valid  output  1  one-cycle pulse, P_DATA holds a new byte
parity_error  output  1  one-cycle pulse, parity mismatch in current frame
stop_error  output  1  one-cycle pulse, stop bit sampled low

Behaviour:
- Reset (async, active-high, any time including mid-frame):
  - P_DATA = 0; data_valid, parity_error and stop_error = 0.
  - State = IDLE; all counters = 0; synchroniser flops = 1.
- RX_IN passes through a 2-flop synchroniser. All references below to "line" mean the synchronised value.
- Config inputs (prescale, parity_enable, parity_type) are static while a frame is in progress. Changing them mid-frame is undefined. Non-legal prescale values are undefined.
- Counters:
  - edge_cnt runs 0..prescale-1 once per bit period, then wraps to 0 and increments bit_cnt.
  - bit_cnt counts bits within the current state.
- Sampling:
  - Three samples are taken at edge_cnt = P/2-1, P/2 and P/2+1 (P = prescale).
  - The bit value is the majority of the three.
  - The bit decision is taken at edge_cnt = P/2+2.
- States:
  - IDLE: edge_cnt = 0. A line = 0 moves to START with edge_cnt = 1 on the next cycle, so the detecting cycle counts as edge 0.
  - START: at the decision point, a majority of 1 (glitch) returns to IDLE immediately with no outputs. Otherwise stay in START until wrap, then go to DATA.
  - DATA: at each decision, shift the bit into the shift register LSB first. After DATA_WIDTH bits (at wrap), go to PARITY if parity_enable = 1, else STOP.
  - PARITY: at the decision point, compare against the computed parity (XOR of data, inverted when parity_type = 1). Record a mismatch in a sticky frame flag. At wrap, go to STOP.
  - STOP: at the decision point, resolve the frame and return to IDLE in the same cycle. The remaining half stop bit is not waited for, so back-to-back frames are accepted.
- Frame resolution (registered, so outputs appear 1 cycle after the stop decision):
  - Stop bit = 1 and no parity mismatch: P_DATA <= shift register; data_valid = 1 for exactly one cycle.
  - Parity mismatch: parity_error pulses 1 cycle. data_valid stays 0 and P_DATA holds.
  - Stop bit = 0: stop_error pulses 1 cycle. data_valid stays 0 and P_DATA holds.
  - Both errors can pulse in the same cycle.
- Latency: for P = 8, 8 data bits, no parity, data_valid rises 9*8 + 6 + 1 = 79 CLK cycles after the first synchronised low of the start bit.
- No backpressure: a consumer that misses the data_valid pulse loses the byte. P_DATA remains stable until the next good frame.
- Line stuck low: after a stop error, the FSM re-enters IDLE, sees 0 and starts a new frame. A repeated stop_error every frame is the required indication.

Test Plan:
- P = 8, no parity, send 0xA5 -> single data_valid pulse with P_DATA = 0xA5, no error pulses; data_valid occurs 79 cycles after the synchronised start edge.
- P = 16, parity_enable = 1, type = 0, send 0x3C with parity bit 0 -> valid, P_DATA = 0x3C. Repeat with parity bit 1 -> parity_error pulse, no data_valid, P_DATA still 0x3C.
- P = 32, odd parity, send back-to-back frames 0x01, 0xFF, 0x80 with no idle between them -> three data_valid pulses in order, no errors.
- Start glitch: drive RX_IN low for 2 cycles at P = 16 -> no outputs, FSM back in IDLE. A following 0x55 frame is received correctly.
- Stop bit forced 0 on 0x12 (P = 8) -> stop_error pulse, no data_valid, P_DATA unchanged.
- Assert RST mid-DATA of a 0x77 frame -> outputs 0 immediately. After release, the next full frame 0x99 is received with data_valid and no spurious error.

Source files
------------

// File: rtl/uart_rx_if.sv
// Bundles the serial line, frame configuration and received-byte outputs of
// the UART receiver. The receiver connects through the slave modport; the
// environment that drives the line and consumes bytes uses the master modport.
interface uart_rx_if #(
    parameter int DATA_WIDTH = 8,
    parameter int PRESCALE_W = 6
);
    logic                  RX_IN;
    logic [PRESCALE_W-1:0] prescale;
    logic                  parity_enable;
    logic                  parity_type;
    logic [DATA_WIDTH-1:0] P_DATA;
    logic                  data_valid;
    logic                  parity_error;
    logic                  stop_error;

    modport master (
        output RX_IN, prescale, parity_enable, parity_type,
        input  P_DATA, data_valid, parity_error, stop_error
    );

    modport slave (
        input  RX_IN, prescale, parity_enable, parity_type,
        output P_DATA, data_valid, parity_error, stop_error
    );
endinterface

// File: rtl/uart_rx.sv
// UART receiver. Oversamples the synchronised serial line by the runtime
// prescale, majority-votes three samples around the middle of each bit and
// recovers start / LSB-first data / optional parity / stop frames. Each frame
// is resolved into a one-cycle data_valid, parity_error or stop_error pulse.
// The stop bit is resolved mid-bit and the FSM returns to IDLE right away, so
// a start bit that immediately follows a stop bit is caught on time.
module uart_rx #(
    parameter int DATA_WIDTH = 8,
    parameter int PRESCALE_W = 6
) (
    input  logic     CLK,
    input  logic     RST,
    uart_rx_if.slave bus
);

    localparam int BIT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [BIT_W-1:0]      LAST_BIT = BIT_W'(DATA_WIDTH - 1);
    localparam logic [BIT_W-1:0]      BIT_ONE  = BIT_W'(1);
    localparam logic [PRESCALE_W-1:0] P_ONE    = PRESCALE_W'(1);
    localparam logic [PRESCALE_W-1:0] P_TWO    = PRESCALE_W'(2);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t                r_state;
    state_t                w_next_state;

    logic                  r_sync1;
    logic                  r_sync2;
    logic [PRESCALE_W-1:0] r_edge_cnt;
    logic [BIT_W-1:0]      r_bit_cnt;
    logic [2:0]            r_samp;
    logic [DATA_WIDTH-1:0] r_shift;
    logic                  r_par_err;
    logic [DATA_WIDTH-1:0] r_p_data;
    logic                  r_data_valid;
    logic                  r_parity_error;
    logic                  r_stop_error;

    logic                  w_line;
    logic [PRESCALE_W-1:0] w_half;
    logic [PRESCALE_W-1:0] w_last_edge;
    logic                  w_wrap;
    logic                  w_decide;
    logic                  w_sample;
    logic                  w_bit;
    logic                  w_last_bit;
    logic                  w_exp_parity;
    logic                  w_par_mismatch;
    logic                  w_frame_done;
    logic                  w_good;
    logic                  w_set_perr;
    logic                  w_set_serr;

    assign w_line       = r_sync2;
    assign w_half       = bus.prescale >> 1;
    assign w_last_edge  = bus.prescale - P_ONE;
    assign w_wrap       = (r_edge_cnt == w_last_edge);
    assign w_decide     = (r_edge_cnt == (w_half + P_TWO));
    assign w_sample     = (r_edge_cnt == (w_half - P_ONE)) ||
                          (r_edge_cnt == w_half) ||
                          (r_edge_cnt == (w_half + P_ONE));
    assign w_bit        = (r_samp[0] & r_samp[1]) | (r_samp[0] & r_samp[2]) |
                          (r_samp[1] & r_samp[2]);
    assign w_last_bit   = (r_bit_cnt == LAST_BIT);
    assign w_exp_parity = (^r_shift) ^ bus.parity_type;

    // Two-flop synchroniser for the asynchronous line; idles high.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= bus.RX_IN;
            r_sync2 <= r_sync1;
        end
    end

    // State register.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic: frame sequencing driven by the edge and bit counters.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (!w_line) begin
                    w_next_state = START;
                end
            end
            START: begin
                if (w_decide && w_bit) begin
                    w_next_state = IDLE;
                end else if (w_wrap) begin
                    w_next_state = DATA;
                end
            end
            DATA: begin
                if (w_wrap && w_last_bit) begin
                    w_next_state = bus.parity_enable ? PARITY : STOP;
                end
            end
            PARITY: begin
                if (w_wrap) begin
                    w_next_state = STOP;
                end
            end
            STOP: begin
                if (w_decide) begin
                    w_next_state = IDLE;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    // Output decode: parity check and frame resolution at the decision points.
    always_comb begin
        w_par_mismatch = 1'b0;
        w_frame_done   = 1'b0;
        if (r_state == PARITY && w_decide) begin
            w_par_mismatch = (w_bit != w_exp_parity);
        end
        if (r_state == STOP && w_decide) begin
            w_frame_done = 1'b1;
        end
        w_good     = w_frame_done && w_bit && !r_par_err;
        w_set_perr = w_frame_done && r_par_err;
        w_set_serr = w_frame_done && !w_bit;
    end

    // Datapath: edge/bit counters, mid-bit samples, shift register, parity flag.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_edge_cnt <= '0;
            r_bit_cnt  <= '0;
            r_samp     <= '0;
            r_shift    <= '0;
            r_par_err  <= 1'b0;
        end else begin
            if (r_state == IDLE) begin
                r_edge_cnt <= w_line ? '0 : P_ONE;
                r_bit_cnt  <= '0;
                if (!w_line) begin
                    r_par_err <= 1'b0;
                end
            end else begin
                if (w_next_state == IDLE || w_wrap) begin
                    r_edge_cnt <= '0;
                end else begin
                    r_edge_cnt <= r_edge_cnt + P_ONE;
                end
                if (w_next_state != r_state) begin
                    r_bit_cnt <= '0;
                end else if (w_wrap) begin
                    r_bit_cnt <= r_bit_cnt + BIT_ONE;
                end
            end
            if (w_sample) begin
                r_samp <= {r_samp[1:0], w_line};
            end
            if (r_state == DATA && w_decide) begin
                r_shift <= {w_bit, r_shift[DATA_WIDTH-1:1]};
            end
            if (w_par_mismatch) begin
                r_par_err <= 1'b1;
            end
        end
    end

    // Registered frame outputs: strobes last one cycle, P_DATA holds the last good byte.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_p_data       <= '0;
            r_data_valid   <= 1'b0;
            r_parity_error <= 1'b0;
            r_stop_error   <= 1'b0;
        end else begin
            r_data_valid   <= w_good;
            r_parity_error <= w_set_perr;
            r_stop_error   <= w_set_serr;
            if (w_good) begin
                r_p_data <= r_shift;
            end
        end
    end

    assign bus.P_DATA       = r_p_data;
    assign bus.data_valid   = r_data_valid;
    assign bus.parity_error = r_parity_error;
    assign bus.stop_error   = r_stop_error;

endmodule
